inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//   Instruction fetch stage: owns the program counter, drives the address of the combinational
//   instruction ROM, registers the returned word with its PC, and hands both to decode over a
//   valid/ready handshake. Execute redirects fetch on a taken branch or a write to R[0].
//   Sits between the instruction ROM (upstream) and decode (downstream).
// PARAMETERS
//   ADDR_W   32  width of PC / ROM address bus
//   INST_W   32  width of ROM instruction word (ISA uses low 16 bits: op[15:12], fields below)
//   RESET_PC 0   PC value loaded on reset
// PORTS
//   clk            in   1       clock, all state updates on rising edge
//   rst            in   1       synchronous reset, active-high
//   en             in   1       fetch enable; 0 = no new fetches
//   rom_addr       out  ADDR_W  ROM address, equals pc register (combinational from reg)
//   rom_inst       in   INST_W  ROM data, valid same cycle as rom_addr
//   redirect_valid in   1       load new PC this cycle (branch/jump from execute)
//   redirect_pc    in   ADDR_W  target PC for redirect
//   inst_valid     out  1       inst/inst_pc hold a fetched instruction
//   inst_ready     in   1       decode accepts inst this cycle
//   inst           out  INST_W  fetched instruction word
//   inst_pc        out  ADDR_W  address the instruction was fetched from
//   fetch_count    out  32      number of instructions captured since reset
// BEHAVIOUR
//   Reset (synchronous, any state, mid-transfer included): pc=RESET_PC, state=IDLE, inst_valid=0,
//     inst=0, inst_pc=0, fetch_count=0; pending output is discarded.
//   FSM states IDLE, RUN, FLUSH. Priority per cycle: rst > redirect_valid > normal operation.
//   IDLE: no capture. en=1 -> RUN next cycle. Held output still drains on inst_ready.
//   RUN: capture when en=1 and (!inst_valid || inst_ready): inst<=rom_inst, inst_pc<=pc,
//     inst_valid<=1, pc<=pc+1, fetch_count+1. en=0 -> IDLE, no capture that cycle.
//     Consumed with no capture: inst_valid<=0.
//   Handshake: transfer when inst_valid && inst_ready. While inst_valid && !inst_ready,
//     inst/inst_pc/inst_valid stay stable and pc does not advance. Back-to-back: one
//     instruction per cycle when inst_ready held 1.
//   Redirect (any non-reset state): pc<=redirect_pc, inst_valid<=0 (held instruction dropped;
//     inst_ready in that cycle is NOT an accepted transfer), no capture, state->FLUSH.
//   FLUSH: one bubble cycle, no capture; next state RUN if en=1 else IDLE. Redirect during
//     FLUSH reloads pc and stays in FLUSH.
//   Latency: rst released with en=1 -> inst_valid high after 2nd rising edge, inst_pc=RESET_PC.
//     Redirect at edge N -> target instruction valid after edge N+2.
//   Arithmetic: pc+1 and fetch_count wrap modulo 2^ADDR_W / 2^32, no flag.
//   inst passed through unmodified (no decode, NOP=all-zero is an ordinary word).
// TESTING
//   Reset, en=1, inst_ready=1, ROM[0..3]=0x3220,0x3180,0x3320,0x3400 -> inst_valid after edge 2,
//     inst_pc 0,1,2,3 on consecutive cycles with matching words, fetch_count=4.
//   inst_ready=0 for 3 cycles with inst_pc=1 -> inst/inst_pc stable, rom_addr stays 2,
//     fetch_count unchanged; release -> inst_pc=2 next cycle, no skip, no duplicate.
//   redirect_valid=1, redirect_pc=4 while inst_pc=7 valid and inst_ready=1 -> inst 7 not
//     counted as transferred, inst_valid=0 one bubble, next inst_pc=4.
//   Redirect on two consecutive cycles to 9 then 4 -> only pc 4 fetched, nothing from 9.
//   pc preloaded via redirect to 0xFFFFFFFF -> inst_pc 0xFFFFFFFF then 0x00000000.
//   rst asserted mid-stream with inst_valid=1, inst_ready=0 -> next cycle inst_valid=0,
//     rom_addr=RESET_PC, fetch_count=0; en=0 afterwards -> no fetch, stays IDLE.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, addresses a combinational instruction ROM and
// hands each captured word with its PC to decode over a valid/ready handshake.
module inst_fetch #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_inst_pc;
    logic [INST_W-1:0]  r_inst;
    logic               r_valid;
    logic [31:0]        r_fetch_count;
    logic               w_capture;
    logic               w_drain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A redirect wins over everything except reset, from any state.
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = FLUSH;
        end else begin
            case (r_state)
                IDLE:    if (en) w_state_next = RUN;
                RUN:     if (!en) w_state_next = IDLE;
                FLUSH:   w_state_next = en ? RUN : IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // A held word drained in the redirect cycle is dropped, not transferred.
    always_comb begin
        w_capture = 1'b0;
        w_drain   = 1'b0;
        if (!redirect_valid) begin
            w_capture = (r_state == RUN) && en && (!r_valid || inst_ready);
            w_drain   = r_valid && inst_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inst        <= '0;
            r_inst_pc     <= '0;
            r_valid       <= 1'b0;
            r_fetch_count <= '0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_inst        <= rom_inst;
            r_inst_pc     <= r_pc;
            r_valid       <= 1'b1;
            r_pc          <= r_pc + ADDR_W'(1);
            r_fetch_count <= r_fetch_count + 32'd1;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign rom_addr    = r_pc;
    assign inst_valid  = r_valid;
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: expected transfers go into a queue, a negedge monitor
// pops and compares every accepted instruction; state checks run inline.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } xfer_t;

    xfer_t exp_q[$];

    inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // ROM image: four program words, then a recognisable pattern tagged with the address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'd0:   rom_word = 32'h0000_3220;
            32'd1:   rom_word = 32'h0000_3180;
            32'd2:   rom_word = 32'h0000_3320;
            32'd3:   rom_word = 32'h0000_3400;
            default: rom_word = {16'hC0DE, a[15:0]};
        endcase
    endfunction

    always_comb rom_inst = rom_word(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] word);
        xfer_t e;
        e.pc   = pc;
        e.word = word;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are stable mid-cycle, so this sees exactly what the next edge will accept.
    initial begin
        xfer_t e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && inst_ready && !redirect_valid) begin
                $display("xfer pc=0x%08h inst=0x%08h count=%0d", inst_pc, inst, fetch_count);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_xfer: got pc 0x%08h, expected no transfer", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_pc", inst_pc, e.pc);
                    check("xfer_inst", inst, e.word);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_rom_addr", rom_addr, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);

        // Streaming from reset
        push(32'd0, 32'h3220); push(32'd1, 32'h3180);
        push(32'd2, 32'h3320); push(32'd3, 32'h3400);
        rst = 1'b0; en = 1'b1; inst_ready = 1'b1;
        tick();
        check("lat_edge1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("lat_edge2_valid", {31'd0, inst_valid}, 32'd1);
        check("lat_edge2_pc", inst_pc, 32'd0);
        check("lat_edge2_inst", inst, 32'h3220);
        tick(); tick(); tick();
        check("stream_pc3", inst_pc, 32'd3);
        check("stream_inst3", inst, 32'h3400);
        check("stream_count", fetch_count, 32'd4);
        en = 1'b0;
        tick();
        check("idle_drain_valid", {31'd0, inst_valid}, 32'd0);
        check("idle_count", fetch_count, 32'd4);

        // Backpressure on inst_pc=1
        push(32'd0, 32'h3220); push(32'd1, 32'h3180); push(32'd2, 32'h3320);
        redirect_valid = 1'b1; redirect_pc = 32'd0; en = 1'b1;
        tick();
        redirect_valid = 1'b0;
        tick(); tick(); tick();
        check("bp_start_pc", inst_pc, 32'd1);
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", {31'd0, inst_valid}, 32'd1);
            check("bp_hold_pc", inst_pc, 32'd1);
            check("bp_hold_inst", inst, 32'h3180);
            check("bp_rom_addr", rom_addr, 32'd2);
            check("bp_count", fetch_count, 32'd6);
        end
        inst_ready = 1'b1;
        tick();
        check("bp_release_pc", inst_pc, 32'd2);
        check("bp_release_inst", inst, 32'h3320);

        // Redirect while inst_pc=7 is valid and ready is high
        push(32'd3, 32'h3400); push(32'd4, 32'hC0DE0004); push(32'd5, 32'hC0DE0005);
        push(32'd6, 32'hC0DE0006);
        tick(); tick(); tick(); tick(); tick();
        check("redir_pre_pc", inst_pc, 32'd7);
        check("redir_pre_count", fetch_count, 32'd12);
        push(32'd4, 32'hC0DE0004);
        redirect_valid = 1'b1; redirect_pc = 32'd4;
        tick();
        redirect_valid = 1'b0;
        check("redir_drop_valid", {31'd0, inst_valid}, 32'd0);
        check("redir_rom_addr", rom_addr, 32'd4);
        tick();
        check("redir_bubble_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        check("redir_target_valid", {31'd0, inst_valid}, 32'd1);
        check("redir_target_pc", inst_pc, 32'd4);
        check("redir_count", fetch_count, 32'd13);
        tick();

        // Back-to-back redirects to 9 then 4
        push(32'd4, 32'hC0DE0004);
        redirect_valid = 1'b1; redirect_pc = 32'd9;
        tick();
        redirect_pc = 32'd4;
        tick();
        redirect_valid = 1'b0;
        check("dbl_redir_valid", {31'd0, inst_valid}, 32'd0);
        check("dbl_redir_rom_addr", rom_addr, 32'd4);
        tick(); tick();
        check("dbl_redir_pc", inst_pc, 32'd4);
        tick();

        // PC wrap
        push(32'hFFFF_FFFF, 32'hC0DEFFFF);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        check("wrap_pc_top", inst_pc, 32'hFFFF_FFFF);
        check("wrap_inst_top", inst, 32'hC0DEFFFF);
        tick();
        check("wrap_pc_zero", inst_pc, 32'd0);
        check("wrap_rom_addr", rom_addr, 32'd1);

        // Reset mid-stream while stalled
        inst_ready = 1'b0;
        tick();
        check("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
        rst = 1'b1; en = 1'b0;
        tick();
        check("midrst_valid", {31'd0, inst_valid}, 32'd0);
        check("midrst_rom_addr", rom_addr, 32'd0);
        check("midrst_count", fetch_count, 32'd0);
        check("midrst_inst_pc", inst_pc, 32'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("post_rst_idle_valid", {31'd0, inst_valid}, 32'd0);
        check("post_rst_idle_rom_addr", rom_addr, 32'd0);
        check("post_rst_idle_count", fetch_count, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
